line_fill_unit: RTL and testbench
=================================

Name: line_fill_unit

Overview:
Fetches a 256-bit cache line from main memory as eight 32-bit beats over a request/acknowledge bus and assembles it in a line register. Sits directly upstream of the store merge stage. On a write miss, LineOut and LineOffset feed the merge stage's CacheLine and Address_LSBs inputs. Also signals the critical word early so the pipeline can restart before the fill completes.

Parameters:
WORD_W, 32, memory beat / word width in bits
WORDS, 8, words per cache line; a power of two; LineOut width = WORD_W*WORDS
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
FillReq  in  1  start fill; accepted only while FillBusy=0
FillAddr  in  ADDR_W  byte address of missing word; [4:2]=word offset, [ADDR_W-1:5]=line address
FillBusy  out  1  fill in progress, including DONE cycle
MemReq  out  1  memory beat request
MemAddr  out  ADDR_W  word-aligned beat address, [1:0]=0
MemAck  in  1  beat accepted; MemData valid in same cycle
MemData  in  WORD_W  beat data
LineOut  out  WORD_W*WORDS  assembled line; word i at bits [32i+31:32i]
LineOffset  out  3  latched FillAddr[4:2]
LineValid  out  1  one-cycle pulse: LineOut complete
CritWord  out  WORD_W  data of requested word
CritValid  out  1  one-cycle pulse: CritWord valid

Behaviour:
- Reset (rst_n=0 at an edge) forces state IDLE. MemReq, FillBusy, LineValid and CritValid go to 0. LineOut, CritWord, MemAddr, LineOffset and the beat counter go to 0. Reset mid-fill abandons the fill: MemReq drops at that same edge and partial data is discarded. Any MemAck on later cycles is ignored.
- States IDLE, FETCH, DONE.
- IDLE:
  - FillReq=1 latches the line address, LineOffset=FillAddr[4:2], start index S and beat count=0, then moves to FETCH.
  - MemReq=1 and FillBusy=1 from the next cycle.
- FETCH:
  - MemReq held at 1. MemAddr = {line, idx, 2'b00}, with idx = (S + count) mod WORDS. The index wraps 7->0.
  - MemAddr is stable while MemAck=0.
  - On each edge with MemAck=1:
    - MemData is written into LineOut word idx; all other words are unchanged.
    - count increments and MemAddr advances at that same edge.
    - MemReq stays high, so back-to-back acks give one beat per cycle.
  - The edge that samples the 8th ack drops MemReq and moves to DONE.
- DONE (one cycle): LineValid=1, FillBusy=1, then back to IDLE. FillReq is ignored here.
- LineOut holds its value until a new fill writes it, so it stays valid after DONE for the merge stage.
- Critical word:
  - When the beat with idx == LineOffset is acked, CritWord is registered with MemData.
  - CritValid pulses 1 in the following cycle.
  - This happens exactly once per fill.
- FillReq while FillBusy=1 is ignored and is not queued.
- Latency with MemAck tied high: FillReq accepted at cycle 0, MemReq 1 in cycles 1-8, LineValid pulse in cycle 9, FillBusy 1 in cycles 1-9. The earliest next accepted FillReq is in cycle 10.
- MemAck while MemReq=0 is ignored.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined: S = FillAddr[4:2], so the requested word is fetched first and CritValid pulses in cycle 2 with MemAck tied high.
- Undefined: S = 0 and beats run 0..7 in order. CritValid pulses the cycle after beat LineOffset is acked.
- LineOut contents and LineValid timing are identical in both builds.

Test Plan:
- Fill, CWF off: FillAddr=0x0000_1014, MemAck tied 1, MemData = 0xA0+idx.
  - MemAddr must go 0x1000, 0x1004, …, 0x101C.
  - LineValid in cycle 9 with word i = 0xA0+i.
  - CritWord=0xA5, CritValid in cycle 7.
- Wrap, CWF on: FillAddr=0x0000_201C.
  - MemAddr order must be 0x201C, 0x2000, …, 0x2018.
  - CritWord=0xA7 in cycle 2.
  - LineOut is identical to the in-order result.
- Stalled acks: MemAck=1 only every third cycle.
  - MemAddr must hold between acks.
  - LineValid follows 1 cycle after the 8th ack.
  - Exactly 8 words are captured.
- Busy rejection: pulse FillReq with FillAddr=0x3000 in cycles 3 and 9 of a running fill.
  - The fill completes with its original address.
  - No second fill starts, and MemReq stays 0 after cycle 9.
- Reset mid-fill: rst_n=0 after the 4th ack, then release and start a new fill with MemAck tied 1.
  - MemReq=0, FillBusy=0 and LineOut=0 the edge after reset.
  - Stray MemAck after reset is ignored.
  - The new fill completes correctly.
- Merge hand-off: fill with FillAddr=0x40C, then drive LineOut and LineOffset into the merge stage with WriteData=0xDEADBEEF.
  - The merged word 3 must equal 0xDEADBEEF.
  - The other words must be unchanged.

Source files
------------

// File: rtl/line_fill_unit.sv
// Cache line fill: fetches WORDS beats over a req/ack bus into LineOut and flags the critical word early.
// Build option: define CRITICAL_WORD_FIRST_EN to start the burst at the requested word instead of word 0.
module line_fill_unit #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 8,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     FillReq,
    input  logic [ADDR_W-1:0]        FillAddr,
    output logic                     FillBusy,
    output logic                     MemReq,
    output logic [ADDR_W-1:0]        MemAddr,
    input  logic                     MemAck,
    input  logic [WORD_W-1:0]        MemData,
    output logic [WORD_W*WORDS-1:0]  LineOut,
    output logic [$clog2(WORDS)-1:0] LineOffset,
    output logic                     LineValid,
    output logic [WORD_W-1:0]        CritWord,
    output logic                     CritValid
);

    localparam int IDX_W     = $clog2(WORDS);
    localparam int BYTE_LSBS = $clog2(WORD_W / 8);
    localparam int LINE_LSB  = IDX_W + BYTE_LSBS;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} fillStateT;

    fillStateT        state;
    logic [IDX_W:0]   beatCount;
    logic [IDX_W-1:0] startIdx;
    logic [IDX_W-1:0] beatIdx;
    logic             lastBeat;
    logic             unusedAddrBits;

    // The word index of the beat in flight lives in MemAddr itself, so it needs no shadow register.
    assign beatIdx        = MemAddr[LINE_LSB-1:BYTE_LSBS];
    assign lastBeat       = (beatCount == (IDX_W+1)'(WORDS - 1));
    assign unusedAddrBits = ^FillAddr[BYTE_LSBS-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
    assign startIdx = FillAddr[LINE_LSB-1:BYTE_LSBS];
`else
    assign startIdx = '0;
`endif

    // NOTE: all state here is sequential, so every assignment is non-blocking; blocking ones would race with readers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            beatCount  <= '0;
            MemReq     <= 1'b0;
            MemAddr    <= '0;
            FillBusy   <= 1'b0;
            LineValid  <= 1'b0;
            CritValid  <= 1'b0;
            CritWord   <= '0;
            LineOffset <= '0;
            // NOTE: the line register is an ordinary flop bank, not a RAM, so it is cleared on reset to drop partial fills.
            LineOut    <= '0;
        end else begin
            LineValid <= 1'b0;
            CritValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (FillReq) begin
                        MemAddr    <= {FillAddr[ADDR_W-1:LINE_LSB], startIdx, {BYTE_LSBS{1'b0}}};
                        LineOffset <= FillAddr[LINE_LSB-1:BYTE_LSBS];
                        beatCount  <= '0;
                        MemReq     <= 1'b1;
                        FillBusy   <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (MemAck) begin
                        LineOut[WORD_W*32'(beatIdx) +: WORD_W] <= MemData;
                        MemAddr[LINE_LSB-1:BYTE_LSBS]         <= beatIdx + IDX_W'(1);
                        beatCount                              <= beatCount + (IDX_W+1)'(1);
                        if (beatIdx == LineOffset) begin
                            CritWord  <= MemData;
                            CritValid <= 1'b1;
                        end
                        if (lastBeat) begin
                            MemReq    <= 1'b0;
                            LineValid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    FillBusy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit: directed scenarios plus random fills against a beat-order reference model.
module tb_line_fill_unit;

    localparam int WORD_W = 32;
    localparam int WORDS  = 8;
    localparam int ADDR_W = 32;

`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    FillReq = 1'b0;
    logic [ADDR_W-1:0]       FillAddr = '0;
    logic                    FillBusy;
    logic                    MemReq;
    logic [ADDR_W-1:0]       MemAddr;
    logic                    MemAck = 1'b0;
    logic [WORD_W-1:0]       MemData = '0;
    logic [WORD_W*WORDS-1:0] LineOut;
    logic [2:0]              LineOffset;
    logic                    LineValid;
    logic [WORD_W-1:0]       CritWord;
    logic                    CritValid;

    line_fill_unit #(.WORD_W(WORD_W), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .FillReq(FillReq), .FillAddr(FillAddr),
        .FillBusy(FillBusy), .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck),
        .MemData(MemData), .LineOut(LineOut), .LineOffset(LineOffset),
        .LineValid(LineValid), .CritWord(CritWord), .CritValid(CritValid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [WORD_W*WORDS-1:0] expLine = '0;
    logic [WORD_W*WORDS-1:0] merged;
    logic [ADDR_W-1:0]       rndAddr;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one complete fill. ackMode: 0 = ack every cycle, 1 = every third cycle, 2 = random.
    task automatic doFill(input logic [ADDR_W-1:0] addr, input int ackMode, input bit seqData,
                          input bit rejectBusy);
        logic [WORD_W-1:0] mem [WORDS];
        int order [WORDS];
        int off, start, k, cyc, doneCyc, critCyc, stall;
        bit ack;
        off   = int'(addr[4:2]);
        start = CWF ? off : 0;
        for (int i = 0; i < WORDS; i++) begin
            mem[i]   = seqData ? WORD_W'(32'hA0 + i) : $urandom;
            order[i] = (start + i) % WORDS;
        end
        check("idleBeforeFill", FillBusy, 0);
        // Stray ack in the request cycle: the unit is idle and must ignore it.
        FillReq = 1'b1; FillAddr = addr; MemAck = 1'b1; MemData = $urandom;
        k = 0; cyc = 0; doneCyc = -1; critCyc = -1; stall = 0;
        while (doneCyc < 0) begin
            tick(); cyc++;
            FillReq = 1'b0;
            if (rejectBusy && (cyc == 3 || cyc == 9)) begin
                FillReq = 1'b1; FillAddr = 32'h0000_3000;
            end
            if (cyc > 300) begin
                checks++; failures++;
                $error("FAIL fillTimeout: observed=%0d beats expected=%0d beats", k, WORDS);
                MemAck = 1'b0;
                return;
            end
            check("memReq", MemReq, 1);
            check("fillBusy", FillBusy, 1);
            check("memAddr", MemAddr, {addr[ADDR_W-1:5], 3'(order[k]), 2'b00});
            check("lineValidEarly", LineValid, 0);
            check("critValid", CritValid, cyc == critCyc);
            if (cyc == critCyc) check("critWord", CritWord, mem[off]);
            case (ackMode)
                0:       ack = 1'b1;
                1:       ack = (cyc % 3 == 0);
                default: ack = ($urandom_range(0, 1) == 1) || (stall >= 3);
            endcase
            MemAck  = ack;
            MemData = ack ? mem[order[k]] : $urandom;
            if (ack) begin
                if (order[k] == off) critCyc = cyc + 1;
                k++; stall = 0;
                if (k == WORDS) doneCyc = cyc + 1;
            end else begin
                stall++;
            end
        end
        tick(); cyc++;
        // Stray ack in the DONE cycle must not disturb the finished line.
        MemAck = 1'b1; MemData = $urandom;
        FillReq = rejectBusy && (cyc == 9);
        if (FillReq) FillAddr = 32'h0000_3000;
        for (int i = 0; i < WORDS; i++) expLine[i*WORD_W +: WORD_W] = mem[i];
        check("lineValid", LineValid, 1);
        check("fillBusyDone", FillBusy, 1);
        check("memReqDone", MemReq, 0);
        check("critValidDone", CritValid, cyc == critCyc);
        if (cyc == critCyc) check("critWordDone", CritWord, mem[off]);
        check("lineOut", LineOut, expLine);
        check("lineOffset", LineOffset, addr[4:2]);
        tick();
        FillReq = 1'b0; MemAck = 1'b0;
        check("lineValidPulse", LineValid, 0);
        check("fillBusyClear", FillBusy, 0);
        check("memReqIdle", MemReq, 0);
        check("critValidIdle", CritValid, 0);
        check("lineOutHeld", LineOut, expLine);
        if (rejectBusy) begin
            tick();
            check("noSecondFillReq", MemReq, 0);
            check("noSecondFillBusy", FillBusy, 0);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rstMemReq", MemReq, 0);
        check("rstFillBusy", FillBusy, 0);
        check("rstLineValid", LineValid, 0);
        check("rstCritValid", CritValid, 0);
        check("rstLineOut", LineOut, 0);
        check("rstCritWord", CritWord, 0);
        check("rstMemAddr", MemAddr, 0);
        check("rstLineOffset", LineOffset, 0);
        rst_n = 1'b1;
        tick();

        doFill(32'h0000_1014, 0, 1'b1, 1'b0);   // in-order / basic fill
        doFill(32'h0000_201C, 0, 1'b1, 1'b0);   // wrap case under critical-word-first
        doFill(32'h0000_50A8, 1, 1'b0, 1'b0);   // stalled acks
        doFill(32'h0000_6004, 0, 1'b0, 1'b1);   // busy rejection in cycles 3 and 9

        // Reset after the 4th ack abandons the fill
        FillReq = 1'b1; FillAddr = 32'h0000_7008; MemAck = 1'b0;
        tick();
        FillReq = 1'b0; MemAck = 1'b1; MemData = $urandom | 32'h1;
        repeat (4) begin
            tick();
            MemData = $urandom | 32'h1;
        end
        check("busyBeforeReset", FillBusy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expLine = '0;
        check("midRstMemReq", MemReq, 0);
        check("midRstFillBusy", FillBusy, 0);
        check("midRstLineOut", LineOut, 0);
        check("midRstMemAddr", MemAddr, 0);
        repeat (2) begin
            tick();
            MemData = $urandom;
            check("strayAckMemReq", MemReq, 0);
            check("strayAckBusy", FillBusy, 0);
            check("strayAckLineOut", LineOut, 0);
            check("strayAckCrit", CritValid, 0);
        end
        MemAck = 1'b0;
        tick();
        doFill(32'h0000_7008, 0, 1'b0, 1'b0);

        // Hand-off to the store merge stage: word LineOffset replaced by the write data
        doFill(32'h0000_040C, 0, 1'b0, 1'b0);
        check("mergeOffset", LineOffset, 3);
        merged = LineOut;
        merged[WORD_W*32'(LineOffset) +: WORD_W] = 32'hDEAD_BEEF;
        for (int i = 0; i < WORDS; i++)
            check("mergeWord", merged[i*WORD_W +: WORD_W],
                  (i == 3) ? 32'hDEAD_BEEF : expLine[i*WORD_W +: WORD_W]);

        // Random fills with random ack patterns
        for (int n = 0; n < 8; n++) begin
            rndAddr = $urandom;
            doFill(rndAddr, int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
